// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-add stages and an OR for the carry.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic h1_s, h1_c, h2_c;

  assign h1_s = x ^ y;
  assign h1_c = x & y;
  assign s    = h1_s ^ ci;
  assign h2_c = h1_s & ci;
  assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH RUN cycles LSB first, then a one-cycle DONE pulse.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             car
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  if (WIDTH < WidthMin || WIDTH > WidthMax) begin : g_width_check
    $error("serial_adder: WIDTH out of range");
  end

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic            carry_q;
  logic [CntW-1:0] cnt_q;
  logic            capture, step;
  logic            fa_s, fa_co;

  full_adder_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (cnt_q == CntLast) state_d = StDone;
      end
      StDone: begin
        // Back-to-back: a start seen here is taken exactly like one in idle.
        if (start) begin
          capture = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        cnt_q   <= '0;
      end else if (step) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
        carry_q <= fa_co;
        if (cnt_q != CntLast) cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Carry into the MSB is carry_q during the last step; compare it to the carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (step && (cnt_q == CntLast)) begin
      ovf_q <= carry_q ^ fa_co;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign car  = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 2, 8 and 32 against an arithmetic model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start2, start8, start32;
  logic [31:0] a_in, b_in;
  logic        cin_in;

  logic        busy2, done2, car2;
  logic [1:0]  sum2;
  logic        busy8, done8, car8;
  logic [7:0]  sum8;
  logic        busy32, done32, car32;
  logic [31:0] sum32;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf2, ovf8, ovf32;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a_in[1:0]),
    .b     (b_in[1:0]),
    .cin   (cin_in),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .car   (car2)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf2)
`endif
  );

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a_in[7:0]),
    .b     (b_in[7:0]),
    .cin   (cin_in),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .car   (car8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(32)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start32),
    .a     (a_in),
    .b     (b_in),
    .cin   (cin_in),
    .busy  (busy32),
    .done  (done32),
    .sum   (sum32),
    .car   (car32)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf32)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: {car,sum} is simply the unsigned sum of the masked operands plus cin.
  function automatic logic [32:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c);
    logic [32:0] m;
    m = (33'h1 << w) - 33'h1;
    return ({1'b0, x} & m) + ({1'b0, y} & m) + {32'h0, c};
  endfunction

  function automatic logic ref_ovf(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic [32:0] r);
    return (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      2:       start2 = v;
      32:      start32 = v;
      default: start8 = v;
    endcase
  endtask

  task automatic get_out(input int w, output logic bsy, output logic dn, output logic [31:0] s,
                         output logic c, output logic o);
    o = 1'b0;
    case (w)
      2: begin
        bsy = busy2; dn = done2; s = {30'h0, sum2}; c = car2;
`ifdef SERIAL_ADDER_OVF_EN
        o = ovf2;
`endif
      end
      32: begin
        bsy = busy32; dn = done32; s = sum32; c = car32;
`ifdef SERIAL_ADDER_OVF_EN
        o = ovf32;
`endif
      end
      default: begin
        bsy = busy8; dn = done8; s = {24'h0, sum8}; c = car8;
`ifdef SERIAL_ADDER_OVF_EN
        o = ovf8;
`endif
      end
    endcase
  endtask

  // Caller must be at a negedge. Operands are scrambled right after capture.
  task automatic run_op(input int w, input logic [31:0] x, input logic [31:0] y, input logic c,
                        input string tag);
    logic [32:0] r;
    logic [31:0] m, s;
    logic        bsy, dn, co, o;
    int          lat;
    r = ref_add(w, x, y, c);
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    a_in = x; b_in = y; cin_in = c;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom);
    lat = 1;
    get_out(w, bsy, dn, s, co, o);
    while (!dn && lat < w + 4) begin
      @(negedge clk);
      lat++;
      get_out(w, bsy, dn, s, co, o);
    end
    check_val({tag, ".lat"}, 64'(lat), 64'(w + 1));
    if (dn) begin
      check_val({tag, ".sum"}, {32'h0, s}, {32'h0, r[31:0] & m});
      check_val({tag, ".car"}, {63'h0, co}, {63'h0, r[w]});
`ifdef SERIAL_ADDER_OVF_EN
      check_val({tag, ".ovf"}, {63'h0, o}, {63'h0, ref_ovf(w, x, y, r)});
`endif
      @(negedge clk);
      get_out(w, bsy, dn, s, co, o);
      check_val({tag, ".pulse"}, {63'h0, dn}, 64'h0);
    end
  endtask

  logic [31:0] q_a[4], q_b[4];
  logic        q_c[4];

  initial begin
    int          k, bc, lat;
    logic [32:0] r;
    rst_n = 1'b0;
    start2 = 1'b0; start8 = 1'b0; start32 = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0;
    #1;
    check_val("rst.busy", {63'h0, busy8}, 64'h0);
    check_val("rst.done", {63'h0, done8}, 64'h0);
    check_val("rst.sum", {56'h0, sum8}, 64'h0);
    check_val("rst.car", {63'h0, car8}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8, 32'h0F, 32'h01, 1'b0, "d_0f_01");
    run_op(8, 32'hFF, 32'h01, 1'b0, "d_ff_01");
    run_op(8, 32'h7F, 32'h01, 1'b0, "d_7f_01");
    run_op(8, 32'h80, 32'h80, 1'b1, "d_80_80");

    // Start re-pulsed mid-run with new operands must be ignored.
    a_in = 32'h12; b_in = 32'h34; cin_in = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bc = 0; k = 0;
    while (!done8 && k < 20) begin
      if (busy8) bc++;
      if (k == 3) begin
        start8 = 1'b1; a_in = 32'h55;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start8 = 1'b0;
    check_val("ign.busy_cycles", 64'(bc), 64'd8);
    check_val("ign.done", {63'h0, done8}, 64'h1);
    check_val("ign.sum", {56'h0, sum8}, 64'h47);
    check_val("ign.car", {63'h0, car8}, 64'h0);
    @(negedge clk);
    check_val("ign.idle", {62'h0, busy8, done8}, 64'h0);

    // Start held high; new operands presented on each DONE cycle.
    for (int i = 0; i < 4; i++) begin
      q_a[i] = $urandom_range(0, 255); q_b[i] = $urandom_range(0, 255); q_c[i] = 1'($urandom);
    end
    a_in = q_a[0]; b_in = q_b[0]; cin_in = q_c[0]; start8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!done8 && lat < 15);
      r = ref_add(8, q_a[i], q_b[i], q_c[i]);
      check_val($sformatf("b2b%0d.lat", i), 64'(lat), 64'd9);
      check_val($sformatf("b2b%0d.sum", i), {56'h0, sum8}, {56'h0, r[7:0]});
      check_val($sformatf("b2b%0d.car", i), {63'h0, car8}, {63'h0, r[8]});
      if (i < 3) begin
        a_in = q_a[i+1]; b_in = q_b[i+1]; cin_in = q_c[i+1];
      end else begin
        start8 = 1'b0;
      end
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    a_in = 32'hAA; b_in = 32'h55; cin_in = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst.busy", {63'h0, busy8}, 64'h0);
    check_val("arst.done", {63'h0, done8}, 64'h0);
    check_val("arst.sum", {56'h0, sum8}, 64'h0);
    check_val("arst.car", {63'h0, car8}, 64'h0);
`ifdef SERIAL_ADDER_OVF_EN
    check_val("arst.ovf", {63'h0, ovf8}, 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8, 32'h01, 32'h02, 1'b1, "post_rst");

    for (int i = 0; i < 40; i++) run_op(8, $urandom, $urandom, 1'($urandom), "r8");
    for (int i = 0; i < 1000; i++) run_op(2, $urandom, $urandom, 1'($urandom), "r2");
    for (int i = 0; i < 1000; i++) run_op(32, $urandom, $urandom, 1'($urandom), "r32");
    run_op(32, 32'hFFFF_FFFF, 32'h0, 1'b1, "e32_max");
    run_op(2, 32'h3, 32'h3, 1'b1, "e2_max");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
